multicycle_controller: RTL and testbench

//  Main sequencing FSM of the multi-cycle RV32I core. Steps each instruction through

---
 rtl/multicycle_controller.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main sequencing FSM of the multi-cycle RV32I core (FETCH/DECODE/EXECUTE/MEM/WRITEBACK).
// Control outputs are combinational decodes of state, ir_q, mem_ready and branch_taken.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes trap in DECODE instead of retiring as NOPs.
module multicycle_controller #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      ir_q,
   input  logic             mem_ready,
   input  logic             branch_taken,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic             alu_a_sel,
   output logic             alu_b_sel,
   output logic             reg_we,
   output logic [1:0]       wb_sel,
   output logic [CNT_W-1:0] instret,
   output logic             bus_error,
   output logic             illegal_instr
);

   localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERROR, S_TRAP
   } state_t;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       addr_sel;
      logic       ir_we;
      logic       pc_we;
      logic [1:0] pc_sel;
      logic       alu_a_sel;
      logic       alu_b_sel;
      logic       reg_we;
      logic [1:0] wb_sel;
   } ctl_t;

   state_t            state_q, state_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic [CNT_W-1:0]  instret_q, instret_d;
   ctl_t              ctl;

   // Opcode classes; the legal set is the one the immediate extender understands.
   logic [6:0] opc;
   logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_op_imm, is_op;
   logic is_legal;

   assign opc       = ir_q[6:0];
   assign is_lui    = (opc == OPC_LUI);
   assign is_auipc  = (opc == OPC_AUIPC);
   assign is_jal    = (opc == OPC_JAL);
   assign is_jalr   = (opc == OPC_JALR);
   assign is_branch = (opc == OPC_BRANCH);
   assign is_load   = (opc == OPC_LOAD);
   assign is_store  = (opc == OPC_STORE);
   assign is_op_imm = (opc == OPC_OP_IMM);
   assign is_op     = (opc == OPC_OP);
   assign is_legal  = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                      is_load | is_store | is_op_imm | is_op;

   // Only the opcode field steers sequencing; the rest of the IR feeds the datapath.
   logic unused_ir_bits;
   assign unused_ir_bits = &{1'b0, ir_q[31:7]};

   // Next-state, control decode, retire counting and memory-timeout tracking.
   always_comb begin
      ctl       = '0;
      state_d   = state_q;
      to_cnt_d  = to_cnt_q;
      instret_d = instret_q;

      case (state_q)
         S_FETCH: begin
            ctl.mem_req = 1'b1;
            if (mem_ready) begin
               ctl.ir_we = 1'b1;
               state_d   = S_DECODE;
            end
         end
         S_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
            state_d = is_legal ? S_EXEC : S_TRAP;
`else
            state_d = S_EXEC;
`endif
         end
         S_EXEC: begin
            ctl.alu_b_sel = ~(is_op | is_branch);
            ctl.alu_a_sel = is_auipc;
            if (is_load || is_store) begin
               state_d = S_MEM;
            end else if (is_branch) begin
               ctl.pc_we  = 1'b1;
               ctl.pc_sel = branch_taken ? 2'b01 : 2'b00;
               instret_d  = instret_q + CNT_W'(1);
               state_d    = S_FETCH;
            end else if (!is_legal) begin
               // Unknown opcode without trapping: step over it like a NOP.
               ctl.pc_we = 1'b1;
               instret_d = instret_q + CNT_W'(1);
               state_d   = S_FETCH;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            ctl.mem_req   = 1'b1;
            ctl.addr_sel  = 1'b1;
            ctl.mem_we    = is_store;
            ctl.alu_b_sel = 1'b1;
            if (mem_ready) begin
               if (is_store) begin
                  ctl.pc_we = 1'b1;
                  instret_d = instret_q + CNT_W'(1);
                  state_d   = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            // ALU selects stay put so JALR/AUIPC results remain valid here.
            ctl.alu_b_sel = ~(is_op | is_branch);
            ctl.alu_a_sel = is_auipc;
            ctl.reg_we    = 1'b1;
            ctl.pc_we     = 1'b1;
            instret_d     = instret_q + CNT_W'(1);
            state_d       = S_FETCH;
            if (is_load)                ctl.wb_sel = 2'b01;
            else if (is_jal || is_jalr) ctl.wb_sel = 2'b10;
            else if (is_lui)            ctl.wb_sel = 2'b11;
            if (is_jal)                 ctl.pc_sel = 2'b01;
            else if (is_jalr)           ctl.pc_sel = 2'b10;
         end
         default: begin
            // ERROR and TRAP hold with every enable low until reset.
         end
      endcase

      if (ctl.mem_req && mem_ready) begin
         to_cnt_d = '0;
      end else if (ctl.mem_req) begin
         to_cnt_d = to_cnt_q + TO_W'(1);
         if (to_cnt_d == TO_W'(MEM_TIMEOUT)) begin
            state_d   = S_ERROR;
            instret_d = instret_q;
         end
      end
      if ((state_d != state_q) && (state_d == S_FETCH || state_d == S_MEM)) begin
         to_cnt_d = '0;
      end
   end

   // State, timeout counter and retired-instruction counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         to_cnt_q  <= '0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         to_cnt_q  <= to_cnt_d;
         instret_q <= instret_d;
      end
   end

   assign {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel,
           alu_a_sel, alu_b_sel, reg_we, wb_sel} = rst ? '0 : ctl;

   assign instret   = instret_q;
   assign bus_error = (state_q == S_ERROR);
`ifdef ILLEGAL_TRAP_EN
   assign illegal_instr = (state_q == S_TRAP);
`else
   assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle control vectors and counters.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// Control vector bit order: mem_req mem_we addr_sel ir_we pc_we pc_sel[1:0] a_sel b_sel reg_we wb_sel[1:0].
module tb_multicycle_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] ir_q = 32'h0;
   logic        mem_ready = 1'b0;
   logic        branch_taken = 1'b0;
   logic        mem_req, mem_we, addr_sel, ir_we, pc_we, alu_a_sel, alu_b_sel, reg_we;
   logic [1:0]  pc_sel, wb_sel;
   logic [31:0] instret;
   logic        bus_error, illegal_instr;
   logic [11:0] ctl;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   multicycle_controller #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .ir_q(ir_q), .mem_ready(mem_ready), .branch_taken(branch_taken),
      .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we), .pc_we(pc_we),
      .pc_sel(pc_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .reg_we(reg_we),
      .wb_sel(wb_sel), .instret(instret), .bus_error(bus_error), .illegal_instr(illegal_instr)
   );

   assign ctl = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel, reg_we, wb_sel};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs on the falling edge, then check the control vector.
   task automatic cyc(input string tag, input logic rdy, input logic tkn, input logic [11:0] exp);
      @(negedge clk);
      mem_ready    = rdy;
      branch_taken = tkn;
      #1;
      check(tag, {20'h0, ctl}, {20'h0, exp});
   endtask

   task automatic do_reset(input logic [31:0] instr);
      @(negedge clk);
      rst       = 1'b1;
      mem_ready = 1'b1;
      ir_q      = instr;
      #1;
      check("rst_ctl", {20'h0, ctl}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_instret", instret, 32'h0);
      check("rst_buserr", {31'h0, bus_error}, 32'h0);
      check("rst_illegal", {31'h0, illegal_instr}, 32'h0);
   endtask

   initial begin
      // ADDI x1,x0,5: F D E W
      do_reset(32'h0050_0093);
      cyc("addi_F", 1'b1, 1'b0, 12'h900);
      cyc("addi_D", 1'b1, 1'b0, 12'h000);
      cyc("addi_E", 1'b1, 1'b0, 12'h008);
      cyc("addi_W", 1'b1, 1'b0, 12'h08C);
      @(negedge clk); #1;
      check("addi_instret", instret, 32'd1);

      // LW with three wait states in MEM: 8 cycles total
      do_reset(32'h0000_A083);
      cyc("lw_F", 1'b1, 1'b0, 12'h900);
      cyc("lw_D", 1'b0, 1'b0, 12'h000);
      cyc("lw_E", 1'b0, 1'b0, 12'h008);
      cyc("lw_M0", 1'b0, 1'b0, 12'hA08);
      cyc("lw_M1", 1'b0, 1'b0, 12'hA08);
      cyc("lw_M2", 1'b0, 1'b0, 12'hA08);
      cyc("lw_M3", 1'b1, 1'b0, 12'hA08);
      cyc("lw_W", 1'b1, 1'b0, 12'h08D);
      cyc("lw_nextF", 1'b0, 1'b0, 12'h800);
      check("lw_instret", instret, 32'd1);

      // BEQ taken then not taken, back to back
      do_reset(32'h0000_0063);
      cyc("beq_F1", 1'b1, 1'b0, 12'h900);
      cyc("beq_D1", 1'b1, 1'b0, 12'h000);
      cyc("beq_E1_taken", 1'b1, 1'b1, 12'h0A0);
      cyc("beq_F2", 1'b1, 1'b0, 12'h900);
      check("beq_instret1", instret, 32'd1);
      cyc("beq_D2", 1'b1, 1'b0, 12'h000);
      cyc("beq_E2_nt", 1'b1, 1'b0, 12'h080);
      cyc("beq_F3", 1'b0, 1'b0, 12'h800);
      check("beq_instret2", instret, 32'd2);

      // JALR x1,0(x1)
      do_reset(32'h0000_80E7);
      cyc("jalr_F", 1'b1, 1'b0, 12'h900);
      cyc("jalr_D", 1'b1, 1'b0, 12'h000);
      cyc("jalr_E", 1'b1, 1'b0, 12'h008);
      cyc("jalr_W", 1'b1, 1'b0, 12'h0CE);

      // JAL, AUIPC, LUI, OP, SW
      do_reset(32'h0000_00EF);
      cyc("jal_F", 1'b1, 1'b0, 12'h900);
      cyc("jal_D", 1'b1, 1'b0, 12'h000);
      cyc("jal_E", 1'b1, 1'b0, 12'h008);
      cyc("jal_W", 1'b1, 1'b0, 12'h0AE);
      do_reset(32'h0000_0097);
      cyc("auipc_F", 1'b1, 1'b0, 12'h900);
      cyc("auipc_D", 1'b1, 1'b0, 12'h000);
      cyc("auipc_E", 1'b1, 1'b0, 12'h018);
      cyc("auipc_W", 1'b1, 1'b0, 12'h09C);
      do_reset(32'h0000_00B7);
      cyc("lui_F", 1'b1, 1'b0, 12'h900);
      cyc("lui_D", 1'b1, 1'b0, 12'h000);
      cyc("lui_E", 1'b1, 1'b0, 12'h008);
      cyc("lui_W", 1'b1, 1'b0, 12'h08F);
      do_reset(32'h0020_81B3);
      cyc("add_F", 1'b1, 1'b0, 12'h900);
      cyc("add_D", 1'b1, 1'b0, 12'h000);
      cyc("add_E", 1'b1, 1'b0, 12'h000);
      cyc("add_W", 1'b1, 1'b0, 12'h084);
      do_reset(32'h0000_0023);
      cyc("sw_F", 1'b1, 1'b0, 12'h900);
      cyc("sw_D", 1'b1, 1'b0, 12'h000);
      cyc("sw_E", 1'b1, 1'b0, 12'h008);
      cyc("sw_M", 1'b1, 1'b0, 12'hE88);
      cyc("sw_nextF", 1'b1, 1'b0, 12'h900);
      check("sw_instret", instret, 32'd1);

      // FETCH timeout: 16 waiting cycles, then sticky bus error
      do_reset(32'h0050_0093);
      for (int i = 0; i < 16; i++) begin
         cyc("to_fetch_wait", 1'b0, 1'b0, 12'h800);
         check("to_buserr_low", {31'h0, bus_error}, 32'h0);
      end
      cyc("to_err_ctl", 1'b1, 1'b0, 12'h000);
      check("to_buserr_set", {31'h0, bus_error}, 32'h1);
      cyc("to_err_hold", 1'b1, 1'b0, 12'h000);
      cyc("to_err_hold2", 1'b1, 1'b0, 12'h000);
      check("to_buserr_sticky", {31'h0, bus_error}, 32'h1);
      check("to_instret", instret, 32'd0);
      do_reset(32'h0050_0093);
      cyc("to_after_rst_F", 1'b1, 1'b0, 12'h900);

      // Unknown opcode 0x7F
      do_reset(32'h0000_007F);
      cyc("ill_F", 1'b1, 1'b0, 12'h900);
      cyc("ill_D", 1'b1, 1'b0, 12'h000);
`ifdef ILLEGAL_TRAP_EN
      cyc("ill_trap", 1'b1, 1'b0, 12'h000);
      check("ill_flag", {31'h0, illegal_instr}, 32'h1);
      cyc("ill_trap_hold", 1'b1, 1'b0, 12'h000);
      check("ill_flag_sticky", {31'h0, illegal_instr}, 32'h1);
      check("ill_instret", instret, 32'd0);
`else
      cyc("ill_nop_E", 1'b1, 1'b0, 12'h088);
      cyc("ill_nextF", 1'b1, 1'b0, 12'h900);
      check("ill_instret", instret, 32'd1);
      check("ill_flag", {31'h0, illegal_instr}, 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
